shift_mix_seq: RTL and testbench
================================

SHIFT_MIX_SEQ -- requirements
Module: shift_mix_seq

Interface
REQ-001 SHALL have parameter N, default 4, bytes per column passed to mix_column; only N=4 supported.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  input state offered.
REQ-005 SHALL have port in_ready  output  1  block accepts input this cycle.
REQ-006 SHALL have port in_state  input  128  post-SubBytes state; byte k at [127-8k -: 8], row k%4, column k/4.
REQ-007 SHALL have port in_last  input  1  final round: bypass MixColumns; sampled with in_state.
REQ-008 SHALL have port out_valid  output  1  result available.
REQ-009 SHALL have port out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port out_state  output  128  ShiftRows+MixColumns result, same byte order as in_state.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, MIX, DONE.
REQ-013 Input handshake: in_valid & in_ready at a rising edge; output handshake: out_valid & out_ready at a rising edge.
REQ-014 On input handshake SHALL load work register with ShiftRows(in_state): out(r,c) = in(r,(c+r) mod 4); store in_last; clear col counter; IDLE->MIX.
REQ-015 In MIX, each edge SHALL replace column col (2-bit counter) with mix_column(column) or, if stored last=1, leave it unchanged; col increments.
REQ-016 SHALL use exactly one mix_column instance, N=4, shared across the 4 columns.
REQ-017 After the col=3 edge SHALL go MIX->DONE; out_valid high exactly 4 cycles after input handshake.
REQ-018 out_valid SHALL be high only in DONE; out_state SHALL equal the work register and stay stable while out_valid & !out_ready.
REQ-019 On output handshake SHALL go DONE->IDLE (unless REQ-024 reload).
REQ-020 in_ready SHALL be high in IDLE only (base build); in_state/in_last ignored otherwise.
REQ-021 in_last=1: out_state = ShiftRows(in_state), same 4-cycle latency.

Reset
REQ-022 rst high SHALL immediately force IDLE, col=0, work register=0, last=0; outputs in_ready=1, out_valid=0, out_state=0, busy=0.
REQ-023 rst asserted in MIX or DONE SHALL discard the in-flight state with no output handshake; first post-reset handshake follows REQ-014.

Configuration
REQ-024 Macro SHIFT_MIX_BACK_TO_BACK_EN defined: in_ready = IDLE | (DONE & out_ready); simultaneous output and input handshake go DONE->MIX with new state loaded, giving one result per 5 cycles. Undefined: REQ-020 holds; one result per 6 cycles minimum.

Verification
REQ-025 in_state=d42711aee0bf98f1b8b45de51e415230, in_last=0 -> out_state=046681e5e0cb199a48f8d37a2806264c, out_valid 4 cycles after accept.
REQ-026 Same in_state, in_last=1 -> out_state=d4bf5d30e0b452aeb84111f11e2798e5.
REQ-027 in_state={db135345}x4, in_last=0 -> out_state={8e4da1bc}x4; in_state all-zero -> all-zero.
REQ-028 out_ready low 10 cycles after out_valid -> out_state stable, in_ready low throughout; out_ready high -> IDLE next cycle.
REQ-029 rst pulse in MIX (col=2) -> out_valid=0, in_ready=1, busy=0 immediately; next vector from REQ-025 correct.
REQ-030 With SHIFT_MIX_BACK_TO_BACK_EN, two back-to-back vectors (REQ-025, REQ-027), out_ready=1 -> results 5 cycles apart, both correct; without macro -> 6 cycles apart.

Source files
------------

// File: rtl/shift_mix_seq.sv
// -----------------------------------------------------------------------------
// shift_mix_seq -- sequential AES ShiftRows + MixColumns round stage.
//
// A post-SubBytes state is accepted on the input handshake and ShiftRows is
// applied while loading the work register. One column per cycle is then passed
// through a single shared mix_column instance, so the result appears four
// cycles after acceptance. On a final round (in_last=1) the columns are left
// untouched and only ShiftRows is applied, with the same latency.
//
// State byte order: byte k lives at [127-8k -: 8], row k%4, column k/4.
//
// Ports:
//   clk        in   1    sole clock, rising edge
//   rst        in   1    asynchronous, active-high reset
//   in_valid   in   1    input state offered
//   in_ready   out  1    block accepts input this cycle
//   in_state   in   128  post-SubBytes state
//   in_last    in   1    final round: bypass MixColumns (sampled with in_state)
//   out_valid  out  1    result available
//   out_ready  in   1    consumer accepts result
//   out_state  out  128  ShiftRows(+MixColumns) result
//   busy       out  1    high in any state other than IDLE
//
// Configuration:
//   SHIFT_MIX_BACK_TO_BACK_EN  when defined, a new input may be accepted in
//                              DONE in the same cycle the result is taken,
//                              giving one result per 5 cycles instead of 6.
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// mix_column -- combinational AES MixColumns on one N-byte column.
//   col_in   in   8N  column, row 0 in the most significant byte
//   col_out  out  8N  mixed column, same byte order
// Each output byte is 2*b[r] ^ 3*b[r+1] ^ b[r+2] ^ b[r+3] over GF(2^8).
// -----------------------------------------------------------------------------
module mix_column #(
   parameter int N = 4
) (
   input  logic [8*N-1:0] col_in,
   output logic [8*N-1:0] col_out
);

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   logic [7:0] col_bytes [N];

   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned and a latch is never inferred.
      col_out = '0;
      for (int r = 0; r < N; r++) begin
         col_bytes[r] = col_in[8*N-1-8*r -: 8];
      end
      for (int r = 0; r < N; r++) begin
         col_out[8*N-1-8*r -: 8] = xtime(col_bytes[r])
                                 ^ xtime(col_bytes[(r+1)%N]) ^ col_bytes[(r+1)%N]
                                 ^ col_bytes[(r+2)%N]
                                 ^ col_bytes[(r+3)%N];
      end
   end

endmodule

module shift_mix_seq #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] in_state,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] out_state,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MIX  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t       state, state_nxt;
   logic [127:0] work;
   logic [127:0] work_mixed;
   logic         last;
   logic [1:0]   col;
   logic [31:0]  col_sel;
   logic [31:0]  col_mixed;
   logic         in_hs;

   // out(r,c) = in(r,(c+r) mod 4)
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
         end
      end
      return o;
   endfunction

   assign in_hs = in_valid & in_ready;

   // Column currently addressed by the counter, fed to the shared mixer.
   always_comb begin
      col_sel = work[127:96];
      case (col)
         2'd0: col_sel = work[127:96];
         2'd1: col_sel = work[95:64];
         2'd2: col_sel = work[63:32];
         2'd3: col_sel = work[31:0];
         default: col_sel = work[127:96];
      endcase
   end

   mix_column #(.N(N)) u_mix_column (
      .col_in  (col_sel),
      .col_out (col_mixed)
   );

   // Work register with the addressed column replaced by its mixed value.
   always_comb begin
      work_mixed = work;
      case (col)
         2'd0: work_mixed[127:96] = col_mixed;
         2'd1: work_mixed[95:64]  = col_mixed;
         2'd2: work_mixed[63:32]  = col_mixed;
         2'd3: work_mixed[31:0]   = col_mixed;
         default: work_mixed = work;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of block ordering.
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_hs) state_nxt = MIX;
         MIX:  if (col == 2'd3) state_nxt = DONE;
         DONE: begin
            if (out_ready) begin
`ifdef SHIFT_MIX_BACK_TO_BACK_EN
               state_nxt = in_valid ? MIX : IDLE;
`else
               state_nxt = IDLE;
`endif
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      out_valid = (state == DONE);
      busy      = (state != IDLE);
`ifdef SHIFT_MIX_BACK_TO_BACK_EN
      in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
`else
      in_ready  = (state == IDLE);
`endif
   end

   assign out_state = work;

   // Datapath: load on accept, then one column per cycle while in MIX.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the work register is reset because out_state is architecturally
      // required to read zero during and after reset; it is not just storage.
      if (rst) begin
         work <= '0;
         last <= 1'b0;
         col  <= 2'd0;
      end else if (in_hs) begin
         work <= shift_rows(in_state);
         last <= in_last;
         col  <= 2'd0;
      end else if (state == MIX) begin
         if (!last) begin
            work <= work_mixed;
         end
         col <= col + 2'd1;
      end
   end

endmodule

// File: tb/tb_shift_mix_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_mix_seq -- self-checking bench for shift_mix_seq.
// Directed AES vectors (FIPS-197 round 1 and a known MixColumns column) are
// applied from a table, followed by hand-written sequences for output stall,
// reset during MIX and back-to-back throughput.
// -----------------------------------------------------------------------------
module tb_shift_mix_seq;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_state;
   logic         in_last;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] out_state;
   logic         busy;

   int total;
   int bad;

   shift_mix_seq #(.N(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic [127:0] st;
      logic         last;
      logic [127:0] exp;
   } vec_t;

   localparam logic [127:0] V_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
   localparam logic [127:0] V_MIX  = 128'h046681e5e0cb199a48f8d37a2806264c;
   localparam logic [127:0] V_LAST = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
   localparam logic [127:0] C_IN   = {4{32'hdb135345}};
   localparam logic [127:0] C_MIX  = {4{32'h8e4da1bc}};

`ifdef SHIFT_MIX_BACK_TO_BACK_EN
   localparam int EXP_GAP = 5;
`else
   localparam int EXP_GAP = 6;
`endif

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Advance to just after the next rising edge; inputs and samples happen here.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one state, measure acceptance-to-out_valid latency, check result
   // and the return to IDLE after the output handshake.
   task automatic run_vec(input string name, input logic [127:0] st,
                          input logic last, input logic [127:0] exp);
      int lat;
      lat = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = st;
      in_last   = last;
      check({name, " ready_idle"}, {127'd0, in_ready}, 128'd1);
      step();
      in_valid = 1'b0;
      in_state = '0;
      in_last  = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         if (out_valid) break;
         step();
         lat = k;
      end
      check({name, " latency"}, 128'(lat), 128'd4);
      check({name, " value"}, out_state, exp);
      step();
      check({name, " back_idle"}, {125'd0, out_valid, busy, in_ready}, 128'b001);
   endtask

   vec_t vecs [4];

   initial begin
      logic [127:0] held;
      logic         stable_ok;
      int           n_res;
      int           res_k [2];
      logic [127:0] res_v [2];
      int           sent;
      logic         hs;

      total = 0;
      bad   = 0;

      vecs[0] = '{name: "round1_mix",  st: V_IN,   last: 1'b0, exp: V_MIX};
      vecs[1] = '{name: "round1_last", st: V_IN,   last: 1'b1, exp: V_LAST};
      vecs[2] = '{name: "col_db13",    st: C_IN,   last: 1'b0, exp: C_MIX};
      vecs[3] = '{name: "all_zero",    st: 128'd0, last: 1'b0, exp: 128'd0};

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_state  = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      check("rst out_state", out_state, 128'd0);
      check("rst in_ready",  {127'd0, in_ready},  128'd1);
      check("rst out_valid", {127'd0, out_valid}, 128'd0);
      check("rst busy",      {127'd0, busy},      128'd0);
      rst = 1'b0;
      step();

      for (int i = 0; i < 4; i++) begin
         run_vec(vecs[i].name, vecs[i].st, vecs[i].last, vecs[i].exp);
      end

      // Output stall: result held for 10 cycles with out_ready low.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_state  = V_IN;
      in_last   = 1'b0;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 20 && !out_valid; k++) step();
      check("stall valid", {127'd0, out_valid}, 128'd1);
      held      = out_state;
      stable_ok = 1'b1;
      for (int k = 0; k < 10; k++) begin
         step();
         if (out_state !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable_ok = 1'b0;
      end
      check("stall stable", {127'd0, stable_ok}, 128'd1);
      check("stall value", out_state, V_MIX);
      out_ready = 1'b1;
      step();
      check("stall release", {125'd0, out_valid, busy, in_ready}, 128'b001);

      // Reset pulse while in MIX with col=2.
      in_valid = 1'b1;
      in_state = C_IN;
      step();
      in_valid = 1'b0;
      step();
      step();
      check("pre_rst busy", {127'd0, busy}, 128'd1);
      rst = 1'b1;
      #1;
      check("mid_rst flags", {125'd0, out_valid, busy, in_ready}, 128'b001);
      check("mid_rst state", out_state, 128'd0);
      #1;
      rst = 1'b0;
      step();
      run_vec("post_rst", V_IN, 1'b0, V_MIX);

      // Back-to-back: two vectors offered continuously, out_ready held high.
      n_res     = 0;
      sent      = 0;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_state  = V_IN;
      in_last   = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (out_valid && n_res < 2) begin
            res_k[n_res] = k;
            res_v[n_res] = out_state;
            n_res++;
         end
         hs = in_valid & in_ready;
         step();
         if (hs) begin
            sent++;
            if (sent == 1) in_state = C_IN;
            else in_valid = 1'b0;
         end
      end
      check("b2b count", 128'(n_res), 128'd2);
      if (n_res == 2) begin
         check("b2b first",  res_v[0], V_MIX);
         check("b2b second", res_v[1], C_MIX);
         check("b2b gap", 128'(res_k[1] - res_k[0]), 128'(EXP_GAP));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
